// File: rtl/ysyx_22041211_pkg.sv
// rtl/ysyx_22041211_pkg.sv - shared types and constants for the instruction fetch unit
package ysyx_22041211_pkg;
    localparam int          INST_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifu_state_e;
endpackage

// File: rtl/ysyx_22041211_pc_reg.sv
// rtl/ysyx_22041211_pc_reg.sv - fetch PC register, loads redirect target or pc+4
module ysyx_22041211_pc_reg
    import ysyx_22041211_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_redirect,
    input  logic [INST_W-1:0] i_target,
    output logic [INST_W-1:0] o_pc
);
    logic [INST_W-1:0] r_pc;
    logic [INST_W-1:0] w_next;

    // Redirect wins over sequential advance; the add wraps naturally at 2^32.
    assign w_next = i_redirect ? (i_target & ~32'h3) : (r_pc + 32'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= w_next;
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/ysyx_22041211_ifu.sv
// rtl/ysyx_22041211_ifu.sv - instruction fetch unit: one outstanding fetch, valid/ready to decode
module ysyx_22041211_ifu
    import ysyx_22041211_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [INST_W-1:0] req_addr_o,
    input  logic              rsp_valid_i,
    input  logic [INST_W-1:0] rsp_data_i,
    input  logic              redirect_i,
    input  logic [INST_W-1:0] redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [INST_W-1:0] pc_o
);
    ifu_state_e        r_state;
    logic              r_drop;
    logic              r_valid;
    logic [INST_W-1:0] r_inst;
    logic [INST_W-1:0] r_pc_o;
    logic [INST_W-1:0] w_pc;
    logic              w_pc_load;

    // Advance only on a decode handshake; r_valid is high exactly in S_HOLD.
    assign w_pc_load = redirect_i | (r_valid & ready_i);

    ysyx_22041211_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pc_load),
        .i_redirect (redirect_i),
        .i_target   (redirect_pc_i),
        .o_pc       (w_pc)
    );

    // Masked by rst so no request leaks out while the memory side is also held in reset.
    assign req_valid_o = (r_state == S_REQ) & ~rst;
    assign req_addr_o  = w_pc;
    assign valid_o     = r_valid;
    assign inst_o      = r_inst;
    assign pc_o        = r_pc_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_drop  <= 1'b0;
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_pc_o  <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (req_ready_i) begin
                        r_state <= S_WAIT;
                        r_drop  <= redirect_i;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid_i) begin
                        if (r_drop || redirect_i) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_inst  <= rsp_data_i;
                            r_pc_o  <= w_pc;
                            r_valid <= 1'b1;
                            r_state <= S_HOLD;
                        end
                    end else if (redirect_i) begin
                        r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_i || ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_drop  <= 1'b0;
                    r_state <= S_REQ;
                end
            endcase
        end
    end
endmodule

// File: doc/ysyx_22041211_ifu.md
# ysyx_22041211_ifu

Instruction fetch unit for the NPC core; sits directly upstream of the decoder and supplies its `inst_i`/`pc_i` pair. It holds the PC and issues one word-aligned fetch at a time to instruction memory over a valid/ready request plus valid response channel. It presents each fetched word with its PC to decode under a valid/ready handshake and accepts PC redirects from execute (branch/jump).

## Interface
- `RESET_PC`, default 32'h8000_0000: PC loaded on reset.
- `clk`  in  1  core clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid_o`  out  1  fetch request valid.
- `req_ready_i`  in  1  memory accepts request.
- `req_addr_o`  out  32  fetch address (always `[1:0]==00`).
- `rsp_valid_i`  in  1  fetch data valid; one-cycle pulse per accepted request.
- `rsp_data_i`  in  32  fetched instruction word.
- `redirect_i`  in  1  pulse; replace PC with `redirect_pc_i`.
- `redirect_pc_i`  in  32  target PC; bits `[1:0]` forced to 00.
- `valid_o`  out  1  `inst_o`/`pc_o` valid toward decoder.
- `ready_i`  in  1  decoder consumes this cycle.
- `inst_o`  out  32  instruction word to decoder `inst_i`.
- `pc_o`  out  32  PC of `inst_o`, to decoder `pc_i`.

## Operation
- Three states: S_REQ, S_WAIT, S_HOLD; plus a 1-bit `drop` flag and a 32-bit `pc` register.
- **S_REQ**
  - `req_valid_o=1`, `req_addr_o=pc`.
  - On `req_valid_o && req_ready_i`, go to S_WAIT.
- **S_WAIT**
  - On `rsp_valid_i`:
    - If `drop=0`, capture `inst_o<=rsp_data_i` and `pc_o<=pc`, then go to S_HOLD.
    - If `drop=1`, discard the word, clear `drop`, and go to S_REQ.
- **S_HOLD**
  - `valid_o=1`; `inst_o` and `pc_o` stay stable.
  - On `valid_o && ready_i`: `pc<=pc+4` (mod 2^32, wraps FFFF_FFFC→0000_0000), then go to S_REQ.
- **Redirect** (highest priority, any state): `pc<=redirect_pc_i & ~3`.
  - S_REQ, request not accepted this cycle: go to S_REQ; the next request uses the new PC.
  - S_REQ, request accepted the same cycle: the accepted request carries the old PC. Set `drop=1` and go to S_WAIT.
  - S_WAIT, no response this cycle: set `drop=1` and stay in S_WAIT.
  - S_WAIT, response this cycle: discard the response, leave `drop=0`, go to S_REQ.
  - S_HOLD: `valid_o` falls next cycle and the held word is discarded, even if `ready_i=1` the same cycle. Go to S_REQ; no `pc+4`.
- At most one request is outstanding; a new request is never issued in S_WAIT.
- `rsp_valid_i` outside S_WAIT is ignored; this is a protocol violation and triggers a bench assertion.

## Timing
- **Reset values:** state=S_REQ, `pc=RESET_PC`, `drop=0`, `inst_o=0`, `pc_o=0`, `valid_o=0`. While `rst=1`, `req_valid_o=0`.
- First `req_valid_o=1` appears in the first cycle after `rst` deasserts.
- **Latency:** with zero-wait memory (`req_ready_i=1`, `rsp_valid_i` the cycle after acceptance), `valid_o` rises 2 cycles after request acceptance.
- **Throughput:** one instruction per 3 cycles at best (REQ, WAIT, HOLD).
- **Redirect:** a redirect in cycle N gives `req_addr_o=target` no later than cycle N+1, or N+2 when a dropped response is still pending; effectively longer if the pending response is delayed.
- `valid_o`, `inst_o` and `pc_o` are registered. No combinational path from `ready_i` to `req_valid_o`.
- **Reset mid-operation:** all state is cleared next cycle. An outstanding response arriving after reset lands in S_REQ and is ignored; the memory side is reset together with this block.

## Structure
- Shared package `ysyx_22041211_pkg`:
  - state enum {S_REQ, S_WAIT, S_HOLD}
  - `RESET_PC` default constant
  - `INST_W=32`
- One sub-module, `ysyx_22041211_pc_reg`: a 32-bit PC register with synchronous reset to `RESET_PC` and a load enable, selecting redirect target or `pc+4`.
- FSM and output registers live in the top module.

## Test plan
- Reset: hold `rst` 3 cycles, release. Expect `req_valid_o=1` with `req_addr_o=8000_0000` on the first cycle after release, and `valid_o=0` throughout reset.
- Streaming: zero-wait memory returning `addr^32'h13`, `ready_i=1`. Expect `pc_o` 8000_0000, 8000_0004, 8000_0008 every 3 cycles, each with matching `inst_o`.
- Backpressure: `ready_i=0` for 5 cycles in S_HOLD. Expect `inst_o`/`pc_o` stable, no new request, and PC advances only after `ready_i=1`.
- Redirect in S_WAIT: response delayed 4 cycles, redirect to 8000_0102. Expect the late response dropped, the next request at 8000_0100, and no `valid_o` for the old word.
- Redirect with simultaneous accept in S_REQ, or in S_HOLD with `ready_i=1`: expect the old word never handshaken and the next delivered `pc_o=` the redirect target.
- Wrap: redirect to FFFF_FFFC and consume it. Expect the next `req_addr_o=0000_0000`.
